// File: rtl/detector_colisiones_pkg.sv
// Shared codes for the game controller: top-level presente values, W_or_L
// encodings, the bonus obstacle type and the collision FSM states.
package detector_colisiones_pkg;

    localparam logic [2:0] P_OFF  = 3'd0;
    localparam logic [2:0] P_WLCM = 3'd1;
    localparam logic [2:0] P_CH   = 3'd2;
    localparam logic [2:0] P_GAME = 3'd3;
    localparam logic [2:0] P_WL   = 3'd4;
    localparam logic [2:0] P_PA   = 3'd5;

    localparam logic [1:0] WL_JUGANDO = 2'b00;
    localparam logic [1:0] WL_PERDIO  = 2'b01;
    localparam logic [1:0] WL_GANO    = 2'b10;

    localparam logic [4:0] TIPO_BONO_DEF = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_JUEGO,
        S_INVULN,
        S_PERDIO,
        S_GANO
    } estado_t;

    // GAME, WL and PA keep a game alive; anything else sends the FSM home.
    function automatic logic en_partida(input logic [2:0] p);
        return (p == P_GAME) || (p == P_WL) || (p == P_PA);
    endfunction

endpackage

// File: rtl/detector_colisiones_sincronizador_flanco.sv
// Two-flop synchronizer for a slow asynchronous level plus a registered
// one-clk pulse on its synchronized rising edge.
module sincronizador_flanco (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulso
);

    logic meta_q, sync_q, prev_q, pulso_q;
    logic pulso_d;

    always_comb begin
        pulso_d = sync_q & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulso_q <= 1'b0;
        end else begin
            meta_q  <= d;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulso_q <= pulso_d;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/detector_colisiones.sv
// Hero/obstacle collision detector: lives, invulnerability window after a hit,
// bonus pickup through a 3-column pipeline, and win/lose reporting.
//   state    | meaning
//   S_IDLE   | no game running, lives reloaded, bonus pipeline empty
//   S_JUEGO  | playing, hits are taken
//   S_INVULN | playing, hits ignored until the tick counter expires
//   S_PERDIO | all lives lost, W_or_L=01 held
//   S_GANO   | all worlds cleared, W_or_L=10 held
module detector_colisiones
    import detector_colisiones_pkg::*;
#(
    parameter logic [1:0] VIDAS_INI = 2'd3,
    parameter logic [2:0] T_INVULN  = 3'd4,
    parameter logic [4:0] TIPO_BONO = TIPO_BONO_DEF,
    parameter logic [6:0] BONO_SEG  = 7'b0000001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_obstaculos,
    input  logic [20:0] display_obs,
    input  logic [4:0]  tipo_obs,
    input  logic [2:0]  presente,
    input  logic [1:0]  mundo,
    input  logic [6:0]  heroe_seg,
    output logic [1:0]  W_or_L,
    output logic        bono_tomado,
    output logic [1:0]  vidas,
    output logic        golpe
);

    estado_t    estado_q, estado_d;
    logic [1:0] vidas_q, vidas_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] bp_q, bp_d;
    logic       bono_q, bono_d;
    logic       golpe_q, golpe_d;
    logic       tick, pausa, hit, bono_ok;
    logic       unused_cols;

    sincronizador_flanco u_sync_obs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk_obstaculos),
        .pulso (tick)
    );

    assign unused_cols = ^display_obs[20:7];
    assign pausa       = (presente == P_PA);
    // A bonus digit in column 0 is never an obstacle.
    assign hit         = ((display_obs[6:0] & heroe_seg) != 7'd0) && !bp_q[0];
    assign bono_ok     = bp_q[0] && ((heroe_seg & BONO_SEG) != 7'd0);

    always_comb begin
        estado_d = estado_q;
        vidas_d  = vidas_q;
        cnt_d    = cnt_q;
        bp_d     = bp_q;
        bono_d   = bono_q;
        golpe_d  = 1'b0;

        if (!en_partida(presente)) begin
            estado_d = S_IDLE;
            vidas_d  = VIDAS_INI;
            cnt_d    = 3'd0;
            bp_d     = 3'd0;
            bono_d   = 1'b0;
        end else if (!pausa) begin
            if (tick) begin
                bp_d   = {(tipo_obs == TIPO_BONO), bp_q[2:1]};
                bono_d = 1'b0;
            end
            case (estado_q)
                S_IDLE: begin
                    vidas_d = VIDAS_INI;
                    cnt_d   = 3'd0;
                    bp_d    = 3'd0;
                    bono_d  = 1'b0;
                    if (presente == P_GAME) estado_d = S_JUEGO;
                end
                S_JUEGO, S_INVULN: begin
                    if (bono_ok) begin
                        bono_d = 1'b1;
                        if (!tick) bp_d[0] = 1'b0;
                    end
                    if (mundo == 2'd3) begin
                        estado_d = S_GANO;
                    end else if (estado_q == S_JUEGO) begin
                        if (hit) begin
                            golpe_d = 1'b1;
                            if (vidas_q <= 2'd1) begin
                                vidas_d  = 2'd0;
                                estado_d = S_PERDIO;
                            end else begin
                                vidas_d  = vidas_q - 2'd1;
                                cnt_d    = T_INVULN;
                                estado_d = S_INVULN;
                            end
                        end
                    end else if (tick) begin
                        // Expiry and a coincident hit: the hit is dropped this clk.
                        cnt_d = (cnt_q != 3'd0) ? cnt_q - 3'd1 : 3'd0;
                        if (cnt_q <= 3'd1) estado_d = S_JUEGO;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= S_IDLE;
            vidas_q  <= VIDAS_INI;
            cnt_q    <= 3'd0;
            bp_q     <= 3'd0;
            bono_q   <= 1'b0;
            golpe_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            vidas_q  <= vidas_d;
            cnt_q    <= cnt_d;
            bp_q     <= bp_d;
            bono_q   <= bono_d;
            golpe_q  <= golpe_d;
        end
    end

    always_comb begin
        case (estado_q)
            S_PERDIO: W_or_L = WL_PERDIO;
            S_GANO:   W_or_L = WL_GANO;
            default:  W_or_L = WL_JUGANDO;
        endcase
    end

    assign vidas       = vidas_q;
    assign bono_tomado = bono_q;
    assign golpe       = golpe_q;

endmodule

// File: tb/tb_detector_colisiones.sv
// Scoreboard bench for detector_colisiones: stimulus updates a game-level model
// and queues expected events/snapshots; a monitor pops and compares them.
module tb_detector_colisiones;
    import detector_colisiones_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_obstaculos = 1'b0;
    logic [20:0] display_obs = '0;
    logic [4:0]  tipo_obs = '0;
    logic [2:0]  presente = P_OFF;
    logic [1:0]  mundo = '0;
    logic [6:0]  heroe_seg = '0;
    logic [1:0]  W_or_L;
    logic        bono_tomado;
    logic [1:0]  vidas;
    logic        golpe;

    always #5 clk = ~clk;

    detector_colisiones dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clk_obstaculos (clk_obstaculos),
        .display_obs    (display_obs),
        .tipo_obs       (tipo_obs),
        .presente       (presente),
        .mundo          (mundo),
        .heroe_seg      (heroe_seg),
        .W_or_L         (W_or_L),
        .bono_tomado    (bono_tomado),
        .vidas          (vidas),
        .golpe          (golpe)
    );

    localparam int EV_HIT  = 0;
    localparam int EV_BONO = 1;
    localparam int M_PLAY  = 0;
    localparam int M_LOST  = 1;
    localparam int M_WON   = 2;

    typedef struct {
        int kind;
        int vidas;
        int wl;
        int bono;
    } exp_t;

    exp_t evq[$];
    exp_t snapq[$];
    int   n_chk = 0;
    int   n_pass = 0;
    logic snap_req = 1'b0;

    // game-level reference model
    int       m_mode;
    int       m_lives;
    int       m_inv;
    bit       m_bp[$];
    bit       m_bono;
    bit       m_paused;
    bit       ov_active;
    logic [6:0] ov_h, ov_d;

    function automatic void check(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endfunction

    function automatic int m_wl();
        return (m_mode == M_LOST) ? 1 : (m_mode == M_WON) ? 2 : 0;
    endfunction

    function automatic void m_restart();
        m_mode  = M_PLAY;
        m_lives = 3;
        m_inv   = 0;
        m_bp    = '{0, 0, 0};
        m_bono  = 0;
    endfunction

    function automatic void m_push(int kind);
        exp_t e;
        e.kind  = kind;
        e.vidas = m_lives;
        e.wl    = m_wl();
        e.bono  = m_bono;
        evq.push_back(e);
    endfunction

    function automatic void m_hit_check();
        if (m_mode == M_PLAY && m_inv == 0 && !m_bp[0] && ov_active && (ov_h & ov_d) != 7'd0) begin
            m_lives--;
            if (m_lives == 0) m_mode = M_LOST;
            else m_inv = 4;
            m_push(EV_HIT);
        end
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        exp_t e;
        e.kind  = -1;
        e.vidas = m_lives;
        e.wl    = m_wl();
        e.bono  = m_bono;
        snapq.push_back(e);
        snap_req = 1'b1;
        cyc(1);
        snap_req = 1'b0;
    endtask

    task automatic do_tick(logic [4:0] t);
        tipo_obs = t;
        cyc(1);
        clk_obstaculos = 1'b1;
        if (!m_paused) begin
            m_bp.push_back(t == TIPO_BONO_DEF);
            void'(m_bp.pop_front());
            m_bono = 0;
            if (m_mode == M_PLAY && m_inv > 0) m_inv--;
            m_hit_check();
        end
        cyc(6);
        clk_obstaculos = 1'b0;
        cyc(6);
    endtask

    task automatic do_overlap(logic [6:0] h, logic [6:0] d, int hold);
        heroe_seg        = h;
        display_obs[6:0] = d;
        display_obs[20:7] = 14'($urandom);
        ov_active = 1;
        ov_h = h;
        ov_d = d;
        if (!m_paused) begin
            if (m_mode == M_PLAY && m_bp[0] && h[0]) begin
                m_bp[0] = 0;
                m_bono  = 1;
                m_push(EV_BONO);
            end
            m_hit_check();
        end
        cyc(hold);
    endtask

    task automatic clear_overlap();
        heroe_seg        = '0;
        display_obs[6:0] = '0;
        ov_active = 0;
        cyc(2);
    endtask

    task automatic do_win(logic [6:0] h, logic [6:0] d);
        mundo            = 2'd3;
        heroe_seg        = h;
        display_obs[6:0] = d;
        if (!m_paused && m_mode == M_PLAY) m_mode = M_WON;
        cyc(3);
        mundo = 2'd0;
        heroe_seg        = '0;
        display_obs[6:0] = '0;
        cyc(2);
    endtask

    task automatic do_pause();
        presente = P_PA;
        m_paused = 1;
        cyc(2);
        do_tick((($urandom_range(0, 1)) != 0) ? TIPO_BONO_DEF : 5'd3);
        do_overlap(7'($urandom_range(1, 127)), 7'h7F, 3);
        clear_overlap();
        presente = P_GAME;
        m_paused = 0;
        cyc(2);
    endtask

    task automatic do_off();
        presente = P_OFF;
        m_restart();
        cyc(3);
        presente = P_GAME;
        cyc(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_restart();
        cyc(1);
        snap();
        rst_n = 1'b1;
        cyc(3);
    endtask

    // monitor
    initial begin
        exp_t e;
        logic bono_prev;
        bono_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (golpe) begin
                check("golpe_esperado", (evq.size() > 0) ? evq[0].kind : -1, EV_HIT);
                if (evq.size() > 0) begin
                    e = evq.pop_front();
                    check("golpe_vidas", int'(vidas), e.vidas);
                    check("golpe_wl", int'(W_or_L), e.wl);
                end
            end
            if (bono_tomado && !bono_prev) begin
                check("bono_esperado", (evq.size() > 0) ? evq[0].kind : -1, EV_BONO);
                if (evq.size() > 0) begin
                    e = evq.pop_front();
                    check("bono_vidas", int'(vidas), e.vidas);
                end
            end
            bono_prev = bono_tomado;
            if (snap_req && snapq.size() > 0) begin
                e = snapq.pop_front();
                check("snap_vidas", int'(vidas), e.vidas);
                check("snap_wl", int'(W_or_L), e.wl);
                check("snap_bono", int'(bono_tomado), e.bono);
                check("snap_golpe", int'(golpe), 0);
                check("snap_eventos_pendientes", evq.size(), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] h, d;
        int op;
        m_paused  = 0;
        ov_active = 0;
        m_restart();

        // reset values
        cyc(2);
        snap();
        rst_n = 1'b1;
        cyc(2);
        presente = P_GAME;
        cyc(3);
        snap();

        // first hit, then invulnerability lasts four ticks
        do_overlap(7'b0001000, 7'b0001000, 3);
        clear_overlap();
        snap();
        for (int i = 0; i < 3; i++) begin
            do_tick(5'd0);
            do_overlap(7'b0001000, 7'b0001000, 2);
            clear_overlap();
        end
        snap();
        do_tick(5'd0);
        do_overlap(7'b0001000, 7'b0001000, 2);
        clear_overlap();
        snap();

        // overlap held across expiry: hit lands the clk after the counter ends
        do_overlap(7'b0100000, 7'b0100001, 2);
        for (int i = 0; i < 4; i++) do_tick(5'd0);
        clear_overlap();
        snap();
        presente = P_WL;
        cyc(4);
        snap();
        presente = P_OFF;
        m_restart();
        cyc(3);
        snap();
        presente = P_GAME;
        cyc(3);

        // bonus pickup, held until next tick, single edge
        do_tick(5'd16);
        do_tick(5'd0);
        do_tick(5'd0);
        do_overlap(7'b0000001, 7'b0000000, 3);
        clear_overlap();
        snap();
        do_overlap(7'b0000001, 7'b0000000, 3);
        clear_overlap();
        do_tick(5'd0);
        snap();

        // bonus column masks a hit
        do_tick(5'd16);
        do_tick(5'd0);
        do_tick(5'd0);
        do_overlap(7'b0001000, 7'b0001000, 3);
        clear_overlap();
        snap();
        do_tick(5'd0);

        // win beats coincident hit
        do_win(7'b0001000, 7'b0001000);
        snap();
        do_off();

        // reset while invulnerable
        do_overlap(7'b0001000, 7'b0001000, 3);
        clear_overlap();
        presente = P_OFF;
        do_reset();
        snap();
        presente = P_GAME;
        cyc(3);

        // randomized operations
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 19);
            if (m_mode != M_PLAY && op < 12 && $urandom_range(0, 2) == 0) op = 17;
            if (op <= 6) begin
                do_tick(($urandom_range(0, 2) == 0) ? TIPO_BONO_DEF : 5'($urandom));
            end else if (op <= 11) begin
                h = 7'($urandom_range(1, 127));
                d = ($urandom_range(0, 1) != 0) ? (h & 7'($urandom)) : 7'($urandom);
                do_overlap(h, d, 3);
                clear_overlap();
            end else if (op == 12) begin
                h = 7'($urandom) & 7'h7E;
                do_win(h, h);
            end else if (op <= 14) begin
                do_pause();
            end else if (op <= 16) begin
                do_overlap(7'b0000001, 7'b0000000, 3);
                clear_overlap();
            end else if (op <= 18) begin
                do_off();
            end else begin
                do_reset();
            end
            snap();
        end

        cyc(5);
        check("eventos_sin_ver", evq.size(), 0);
        check("snapshots_sin_ver", snapq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/detector_colisiones.md
DETECTOR_COLISIONES -- requirements
Module: detector_colisiones

Interface
REQ-001 Parameters, one per line: VIDAS_INI, 2'd3, lives at game start; T_INVULN, 3'd4, obstacle ticks of invulnerability after a hit; TIPO_BONO, 5'd16, tipo_obs code marking a bonus; BONO_SEG, 7'b0000001, segment mask in which the hero collects a bonus.
REQ-002 Ports, one per line: clk  in  1  system clock. rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 clk_obstaculos  in  1  obstacle scroll clock, sampled as data, never used as a clock.
REQ-004 display_obs  in  21  scrolling obstacle digits; [6:0] is the column under the hero.
REQ-005 tipo_obs  in  5  type of the obstacle entering column [20:14].
REQ-006 presente  in  3  top-level state (OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5).
REQ-007 mundo  in  2  current world; 3 means all worlds cleared.
REQ-008 heroe_seg  in  7  hero segment pattern in column 0.
REQ-009 W_or_L  out  2  2'b00 playing, 2'b01 lost, 2'b10 won.
REQ-010 bono_tomado  out  1  bonus collected, level.
REQ-011 vidas  out  2  lives remaining.
REQ-012 golpe  out  1  one-clk pulse per hit taken.

Function
REQ-013 tick: clk_obstaculos SHALL pass a 2-flop synchronizer; tick is a one-clk pulse on the synchronized rising edge (3 clk latency from input edge).
REQ-014 Bonus pipeline: 3-bit shift register bp; on tick bp[2]<=(tipo_obs==TIPO_BONO), bp[1]<=bp[2], bp[0]<=bp[1]; bp[0] marks the column-0 bonus.
REQ-015 hit = (display_obs[6:0] & heroe_seg) != 0, evaluated every clk.
REQ-016 FSM states: IDLE, JUEGO, INVULN, PERDIO, GANO.
REQ-017 IDLE: W_or_L=00, vidas=VIDAS_INI, bp cleared; presente==GAME -> JUEGO.
REQ-018 JUEGO: hit -> vidas-1, golpe pulse, invulnerability counter = T_INVULN, go to INVULN; if vidas==1 at the hit, go to PERDIO instead, with vidas=0.
REQ-019 INVULN: hits ignored; counter decrements on each tick; reaching 0 -> JUEGO on the same clk.
REQ-020 JUEGO or INVULN with mundo==3 -> GANO; win takes priority over a simultaneous hit.
REQ-021 PERDIO: W_or_L=01 held; GANO: W_or_L=10 held; both return to IDLE only when presente is neither GAME nor WL.
REQ-022 Any state: presente not GAME/WL/PA -> IDLE next clk. PA freezes all state, counters and bp; ticks are ignored during PA.
REQ-023 Bonus: in JUEGO or INVULN, bp[0]==1 and (heroe_seg & BONO_SEG)!=0 -> bono_tomado=1 and bp[0] cleared; bono_tomado held until the next tick, then 0; at most one rising edge per bonus.
REQ-024 A bonus column never counts as a hit (hit masked while bp[0]==1).
REQ-025 vidas saturates at 0; no underflow.
REQ-026 Simultaneous hit and tick in INVULN with counter==1: counter expires, hit ignored that clk.

Reset
REQ-027 rst_n low SHALL force: state IDLE, W_or_L=00, vidas=VIDAS_INI, bono_tomado=0, golpe=0, bp=0, synchronizer flops=0, counter=0.
REQ-028 Reset mid-game SHALL abort immediately; no golpe or bono_tomado is emitted on release.

Structure
REQ-029 State codes (presente values), W_or_L codes and TIPO_BONO SHALL live in a shared package used by generador_obstaculos and this block.
REQ-030 Sub-module sincronizador_flanco (2-flop sync + rising-edge pulse) SHALL be instantiated for clk_obstaculos.

Verification
REQ-031 presente=GAME, heroe_seg=7'b0001000, display_obs[6:0]=7'b0001000 -> golpe pulse, vidas 3->2, state INVULN.
REQ-032 Repeated overlap during 4 ticks after a hit -> vidas stays 2; overlap on the 5th tick -> vidas 1.
REQ-033 Three separated hits -> vidas=0, W_or_L=01 held until presente=OFF, then 00 and vidas=3.
REQ-034 tipo_obs=16 sampled, two more ticks, heroe_seg=7'b0000001 -> bono_tomado=1 until next tick, no golpe.
REQ-035 mundo=3 coincident with an overlap -> W_or_L=10, vidas unchanged.
REQ-036 rst_n low during INVULN, released -> IDLE, vidas=3, all outputs 0.
